// File: rtl/nubus_sram.sv
// nubus_sram - on-card SRAM target behind the NuBus slave state machine.
//
// Purpose:
//   Byte-lane writable memory of 2^MEMORY_W words of DATA_W bits. Each
//   request that is decoded for this card (standard slot or expansion
//   space) is latched, held for a per-access number of wait cycles and then
//   completed with a one-cycle registered ready pulse. An optional sequencer
//   zeroes the whole array after every reset.
//
// Ports:
//   mem_clk          clock, rising edge
//   mem_reset        synchronous active-high reset
//   mem_valid        request, held by the master until it samples ready
//   mem_wstrb        byte-lane write strobes, all zero = read
//   mem_addr         byte address; word index = mem_addr[ADDR_LSB +: MEMORY_W]
//   mem_wdata        write data
//   mem_myslot       standard-slot space decode
//   mem_myexp        expansion space decode
//   mem_wait_clocks  extra wait cycles, sampled when the request is accepted
//   mem_rdata_o      registered read data
//   mem_ready_o      one-cycle completion pulse
//   mem_write_o      qualifies mem_ready_o for a completed write
//   mem_busy_o       high while the post-reset clear sequencer runs

module nubus_sram #(
  parameter int DATA_W         = 32,
  parameter int MEMORY_W       = 16,
  parameter int WAIT_W         = 3,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                mem_clk,
  input  logic                mem_reset,
  input  logic                mem_valid,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [31:0]         mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_myslot,
  input  logic                mem_myexp,
  input  logic [WAIT_W-1:0]   mem_wait_clocks,
  output logic [DATA_W-1:0]   mem_rdata_o,
  output logic                mem_ready_o,
  output logic                mem_write_o,
  output logic                mem_busy_o
);

  localparam int LANES    = DATA_W / 8;
  localparam int ADDR_LSB = $clog2(LANES);
  localparam int DEPTH    = 1 << MEMORY_W;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic [MEMORY_W-1:0] clr_idx_q, clr_idx_d;
  logic [MEMORY_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [LANES-1:0]    wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                write_q, write_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                sel;
  logic                do_access;
  logic [DATA_W-1:0]   rd_word;
  logic                wr_en;
  logic [MEMORY_W-1:0] wr_idx;
  logic [LANES-1:0]    wr_mask;
  logic [DATA_W-1:0]   wr_data;

  // Address bits outside the word index simply alias; fold them into a
  // sink so the whole bus is visibly consumed.
  logic                addr_unused;

  assign sel         = mem_valid & (mem_myslot | mem_myexp);
  assign addr_unused = ^mem_addr;

  // State register and all control/data flops. Reset wins over every
  // transition, so an access in flight is simply dropped.
  always_ff @(posedge mem_clk) begin
    if (mem_reset) begin
      state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      cnt_q     <= '0;
      clr_idx_q <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      write_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clr_idx_q <= clr_idx_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      write_q   <= write_d;
    end
  end

  // Next-state logic. The request is captured once in IDLE; from then on
  // only mem_valid is watched, so a master dropping it aborts the access.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clr_idx_d = clr_idx_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    do_access = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_idx_d = clr_idx_q + MEMORY_W'(1);
        if (&clr_idx_q) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (sel) begin
          idx_d   = mem_addr[ADDR_LSB +: MEMORY_W];
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          cnt_d   = mem_wait_clocks;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!mem_valid) begin
          state_d = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - WAIT_W'(1);
        end else begin
          do_access = 1'b1;
          state_d   = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output and datapath logic. Ready/write/rdata are loaded on the edge
  // that performs the access so they are visible for exactly the ACK cycle.
  // Strobed lanes read back as zero, which also makes a pure write clear
  // the read-data register.
  always_comb begin
    rd_word = mem_q[idx_q];
    wr_en   = 1'b0;
    wr_idx  = idx_q;
    wr_mask = wstrb_q;
    wr_data = wdata_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    write_d = 1'b0;
    if (state_q == ST_CLEAR) begin
      wr_en   = 1'b1;
      wr_idx  = clr_idx_q;
      wr_mask = '1;
      wr_data = '0;
    end else if (do_access) begin
      wr_en   = |wstrb_q;
      ready_d = 1'b1;
      write_d = |wstrb_q;
      for (int i = 0; i < LANES; i++) begin
        rdata_d[8*i +: 8] = wstrb_q[i] ? 8'h00 : rd_word[8*i +: 8];
      end
    end
    if (mem_reset) begin
      wr_en = 1'b0;
    end
  end

  // Storage array, byte-lane write enables; contents are not reset.
  always_ff @(posedge mem_clk) begin
    if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_mask[i]) begin
          mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  assign mem_rdata_o = rdata_q;
  assign mem_ready_o = ready_q;
  assign mem_write_o = write_q;
  assign mem_busy_o  = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_nubus_sram.sv
// tb_nubus_sram - self-checking bench for nubus_sram (32-bit, 16 words,
// 3-bit wait counter, clear-on-reset enabled). A plain word array models
// the memory; expected read data and ready timing are derived from it.

module tb_nubus_sram;

  logic        mem_clk;
  logic        mem_reset;
  logic        mem_valid;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_myslot;
  logic        mem_myexp;
  logic [2:0]  mem_wait_clocks;
  logic [31:0] mem_rdata_o;
  logic        mem_ready_o;
  logic        mem_write_o;
  logic        mem_busy_o;

  int          checks;
  int          errors;
  logic [31:0] model_mem [16];
  int          busy_cycles;
  int          ready_count;
  logic [31:0] tmp_word;

  nubus_sram #(
    .DATA_W         (32),
    .MEMORY_W       (4),
    .WAIT_W         (3),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .mem_clk         (mem_clk),
    .mem_reset       (mem_reset),
    .mem_valid       (mem_valid),
    .mem_wstrb       (mem_wstrb),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_myslot      (mem_myslot),
    .mem_myexp       (mem_myexp),
    .mem_wait_clocks (mem_wait_clocks),
    .mem_rdata_o     (mem_rdata_o),
    .mem_ready_o     (mem_ready_o),
    .mem_write_o     (mem_write_o),
    .mem_busy_o      (mem_busy_o)
  );

  // Free-running clock, period 10.
  initial begin
    mem_clk = 1'b0;
    forever #5 mem_clk = ~mem_clk;
  end

  // Hard stop in case something is badly broken.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock; inputs change and outputs are sampled 1 unit after
  // the rising edge.
  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 16; i++) model_mem[i] = 32'h0;
  endtask

  // Counts cycles with busy high, starting from the current sample point.
  task automatic waitClear(output int cycles);
    cycles = 0;
    for (int k = 0; k < 40 && mem_busy_o === 1'b1; k++) begin
      cycles++;
      tick();
    end
  endtask

  // One complete access: accept at E0, scramble the live inputs, expect
  // ready exactly N+1 edges later for one cycle, then update the model.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb, input int n);
    int          idx;
    int          ready_edge;
    int          dec;
    logic [31:0] exp_rd;
    idx = int'(addr[5:2]);
    for (int i = 0; i < 4; i++)
      exp_rd[8*i +: 8] = wstrb[i] ? 8'h00 : model_mem[idx][8*i +: 8];
    dec             = $urandom_range(1, 3);
    mem_valid       = 1'b1;
    mem_myslot      = dec[0];
    mem_myexp       = dec[1];
    mem_addr        = addr;
    mem_wdata       = wdata;
    mem_wstrb       = wstrb;
    mem_wait_clocks = 3'(n);
    tick();
    mem_addr        = $urandom;
    mem_wdata       = $urandom;
    mem_wstrb       = 4'($urandom);
    mem_wait_clocks = 3'($urandom);
    ready_edge = -1;
    for (int k = 1; k <= n + 1; k++) begin
      tick();
      if (mem_ready_o === 1'b1 && ready_edge < 0) ready_edge = k;
    end
    checkOutput("ready_latency", 32'(ready_edge), 32'(n + 1));
    checkOutput("write_flag", 32'(mem_write_o), 32'(wstrb != 4'h0));
    checkOutput("rdata", mem_rdata_o, exp_rd);
    mem_valid  = 1'b0;
    mem_myslot = 1'b0;
    mem_myexp  = 1'b0;
    tick();
    checkOutput("ready_pulse_end", 32'(mem_ready_o), 32'd0);
    for (int i = 0; i < 4; i++)
      if (wstrb[i]) model_mem[idx][8*i +: 8] = wdata[8*i +: 8];
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    mem_reset       = 1'b1;
    mem_valid       = 1'b0;
    mem_wstrb       = 4'h0;
    mem_addr        = 32'h0;
    mem_wdata       = 32'h0;
    mem_myslot      = 1'b0;
    mem_myexp       = 1'b0;
    mem_wait_clocks = 3'd0;
    clearModel();

    // Power-up reset and initial clear.
    repeat (3) tick();
    checkOutput("reset_ready", 32'(mem_ready_o), 32'd0);
    checkOutput("reset_write", 32'(mem_write_o), 32'd0);
    checkOutput("reset_rdata", mem_rdata_o, 32'd0);
    checkOutput("reset_busy", 32'(mem_busy_o), 32'd1);
    mem_reset = 1'b0;
    waitClear(busy_cycles);
    checkOutput("clear_cycles", 32'(busy_cycles), 32'd16);

    // Clear sequencer wipes a preloaded word.
    applyStimulus(32'h14, 32'hDEADBEEF, 4'hF, 0);
    applyStimulus(32'h14, 32'h0, 4'h0, 1);
    checkOutput("preload_read", mem_rdata_o, 32'hDEADBEEF);
    mem_reset = 1'b1;
    tick();
    mem_reset = 1'b0;
    clearModel();
    checkOutput("pulse_rdata", mem_rdata_o, 32'd0);
    checkOutput("pulse_busy", 32'(mem_busy_o), 32'd1);
    waitClear(busy_cycles);
    checkOutput("reclear_cycles", 32'(busy_cycles), 32'd16);
    applyStimulus(32'h14, $urandom, 4'h0, 2);
    checkOutput("cleared_word5", mem_rdata_o, 32'h0);

    // Full-word write and read-back.
    applyStimulus(32'h40, 32'h12345678, 4'hF, 0);
    applyStimulus(32'h40, $urandom, 4'h0, 0);
    checkOutput("fullword_read", mem_rdata_o, 32'h12345678);

    // Byte strobes and mixed-strobe read.
    applyStimulus(32'h40, 32'hAABBCCDD, 4'b0100, 1);
    applyStimulus(32'h40, $urandom, 4'h0, 3);
    checkOutput("lane2_read", mem_rdata_o, 32'h12BB5678);
    applyStimulus(32'h40, $urandom, 4'b0001, 0);
    checkOutput("mixed_read", mem_rdata_o, 32'h12BB5600);

    // Wait-state sweep with random traffic.
    for (int n = 0; n < 8; n++)
      applyStimulus($urandom, $urandom, 4'($urandom), n);

    // Decode gating: valid without slot/expansion decode is ignored.
    tmp_word        = $urandom | 32'h1;
    mem_valid       = 1'b1;
    mem_myslot      = 1'b0;
    mem_myexp       = 1'b0;
    mem_addr        = 32'h28;
    mem_wdata       = tmp_word;
    mem_wstrb       = 4'hF;
    mem_wait_clocks = 3'd0;
    ready_count     = 0;
    repeat (12) begin
      tick();
      if (mem_ready_o === 1'b1) ready_count++;
    end
    mem_valid = 1'b0;
    tick();
    checkOutput("nodecode_ready", 32'(ready_count), 32'd0);
    applyStimulus(32'h28, 32'h0, 4'h0, 0);

    // Abort: write with N=5, valid dropped once the counter reaches 2.
    applyStimulus(32'h24, 32'hCAFEF00D, 4'hF, 0);
    mem_valid       = 1'b1;
    mem_myexp       = 1'b1;
    mem_addr        = 32'h24;
    mem_wdata       = 32'h5555AAAA;
    mem_wstrb       = 4'hF;
    mem_wait_clocks = 3'd5;
    tick();
    ready_count = 0;
    repeat (3) begin
      tick();
      if (mem_ready_o === 1'b1) ready_count++;
    end
    mem_valid = 1'b0;
    mem_myexp = 1'b0;
    repeat (8) begin
      tick();
      if (mem_ready_o === 1'b1) ready_count++;
    end
    checkOutput("abort_ready", 32'(ready_count), 32'd0);
    applyStimulus(32'h24, 32'h0, 4'h0, 0);
    checkOutput("abort_unchanged", mem_rdata_o, 32'hCAFEF00D);

    // Random back-to-back traffic.
    for (int t = 0; t < 24; t++)
      applyStimulus($urandom, $urandom, 4'($urandom), int'($urandom_range(0, 7)));

    // Reset in the middle of a waited write.
    applyStimulus(32'h24, 32'h0, 4'h0, 0);
    mem_valid       = 1'b1;
    mem_myslot      = 1'b1;
    mem_addr        = 32'h24;
    mem_wdata       = 32'h0F0F0F0F;
    mem_wstrb       = 4'hF;
    mem_wait_clocks = 3'd6;
    tick();
    ready_count = 0;
    repeat (2) begin
      tick();
      if (mem_ready_o === 1'b1) ready_count++;
    end
    mem_reset = 1'b1;
    tick();
    mem_reset  = 1'b0;
    mem_valid  = 1'b0;
    mem_myslot = 1'b0;
    clearModel();
    checkOutput("midwait_ready_seen", 32'(ready_count), 32'd0);
    checkOutput("midwait_ready", 32'(mem_ready_o), 32'd0);
    checkOutput("midwait_write", 32'(mem_write_o), 32'd0);
    checkOutput("midwait_rdata", mem_rdata_o, 32'd0);
    checkOutput("midwait_busy", 32'(mem_busy_o), 32'd1);
    waitClear(busy_cycles);
    checkOutput("midwait_clear_cycles", 32'(busy_cycles), 32'd16);
    applyStimulus(32'h24, 32'h0, 4'h0, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nubus_sram.md
# nubus_sram

Parametrised on-card SRAM target for the XiBus NuBus slave. It replaces the fixed 32-bit, combinational-read, shift-chain-wait memory. Width, depth and wait-counter width are configurable, read data and ready are registered, and the wait count is sampled per access. It sits behind the NuBus slave state machine on the same `mem_*` bus. It adds slot/expansion decode gating, abort-on-valid-drop, and an optional post-reset clear sequencer.

## Interface
- `DATA_W`, default 32: data width in bits; multiple of 8, at least 8; `LANES = DATA_W/8`.
- `MEMORY_W`, default 16: log2 of the number of words.
- `WAIT_W`, default 3: width of `mem_wait_clocks`.
- `CLEAR_ON_RESET`, default 1: if 1, zero every word after reset; if 0, contents are untouched by reset.
- `mem_clk` in 1: clock, rising edge.
- `mem_reset` in 1: synchronous, active-high reset.
- `mem_valid` in 1: request; held high by the master until it samples `mem_ready_o`.
- `mem_wstrb` in LANES: byte-lane write strobes; all zero means read.
- `mem_addr` in 32: byte address; word index `= mem_addr[ADDR_LSB +: MEMORY_W]`, where `ADDR_LSB = log2(LANES)`; upper bits alias.
- `mem_wdata` in DATA_W: write data.
- `mem_myslot` in 1: standard-slot space decode.
- `mem_myexp` in 1: expansion space decode.
- `mem_wait_clocks` in WAIT_W: extra wait cycles, sampled at accept.
- `mem_rdata_o` out DATA_W: registered read data.
- `mem_ready_o` out 1: one-cycle completion pulse.
- `mem_write_o` out 1: high together with `mem_ready_o` when the completed access was a write.
- `mem_busy_o` out 1: high while the clear sequencer runs.

## Operation
- `sel = mem_valid & (mem_myslot | mem_myexp)`.
- States: CLEAR, IDLE, WAIT, ACK.
- **CLEAR:** writes 0 to word `clr_idx` each cycle, starting at 0. After writing word `2^MEMORY_W-1`, go to IDLE. `mem_busy_o=1` throughout. Requests are ignored during CLEAR, with no latch and no ready.
- **IDLE:** on `sel`, latch addr, wdata, wstrb and `cnt = mem_wait_clocks`, then go to WAIT. Without `sel`, stay in IDLE.
- **WAIT:**
  - If `mem_valid=0`: abort. Go to IDLE with no write and no ready.
  - Else if `cnt != 0`: `cnt--`.
  - Else (`cnt == 0`): perform the access and go to ACK.
- **Access, write:** update only the lanes with `wstrb[i]=1`.
- **Access, read:** `rdata_o` lane i = `mem[idx]` lane i.
- **Access, mixed strobe:** lanes with `wstrb[i]=1` return 0 in `rdata_o`, as on a pure write.
- **ACK:** `mem_ready_o=1`, `mem_write_o=(wstrb!=0)`. Always go to IDLE next, ignoring `mem_valid`; the master's request from this transaction is still visible at that edge.
- Latched address, data and strobes are used for the access. Changes to the inputs after accept have no effect.
- `mem_rdata_o` holds its last read value until the next read completes. It is cleared to 0 on reset and on write completion.

## Timing
- Reset, synchronous: at the first rising edge with `mem_reset=1`:
  - state goes to CLEAR if `CLEAR_ON_RESET`, else IDLE;
  - `mem_ready_o=0`, `mem_write_o=0`, `mem_rdata_o=0`, `cnt=0`, `clr_idx=0`;
  - `mem_busy_o=1` if `CLEAR_ON_RESET`, else 0.
- Reset mid-access: the access is aborted. No write happens unless the completing edge is the one without reset. Reset has priority over every transition.
- Let E0 be the accept edge and N the sampled `mem_wait_clocks`. The access happens at E(N+1). `mem_ready_o` is high during the cycle after E(N+1) and low after E(N+2).
- Worst case: N = `2^WAIT_W-1`.
- Back-to-back requests: minimum spacing is one IDLE cycle. The next accept is no earlier than E(N+3).
- Clear duration: `2^MEMORY_W` cycles after reset deasserts, then one cycle into IDLE.
- A `sel` arriving on the cycle CLEAR ends is accepted at the first IDLE edge, not earlier.
- `mem_ready_o` and `mem_write_o` are never high outside ACK. Both are registered, with no combinational path from the inputs.

## Test plan
- **Clear sequencer:** `MEMORY_W=4`, `CLEAR_ON_RESET=1`. Preload word 5 = `DEADBEEF`, pulse reset. `mem_busy_o` stays high exactly 16 cycles. A read of addr `0x14` then returns `00000000`.
- **Full-word write and read-back:** N=0, write `0x12345678` to `0x40` with strobes `1111`. Ready is high one cycle after accept, with `mem_write_o=1`. Reading `0x40` returns `12345678`.
- **Byte strobes:** write `AABBCCDD` with `wstrb=0100` over `12345678`. A read returns `12BB5678`. A mixed read with `wstrb=0001` returns `12BB5600`.
- **Wait states:** sweep N=0..7. Ready rises exactly N+1 edges after accept and lasts one cycle. Changing `mem_wait_clocks` mid-WAIT has no effect.
- **Decode and abort:** `mem_valid=1` with `mem_myslot=0` and `mem_myexp=0` never produces ready. A write with N=5 that drops `mem_valid` at cnt=2 leaves memory unchanged and produces no ready.
- **Reset mid-WAIT:** assert reset during WAIT. No ready and no write occur. After reset, every output reads 0.
